// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is combinational; training and allocation happen at the clock edge.
module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        btb_found,
    output logic [31:0] btb_target,
    output logic        branch_prediction,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [31:0]      target [ENTRIES];
    logic [1:0]       ctr    [ENTRIES];

    logic [INDEX_W-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic [INDEX_W-1:0] u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               f_hit;
    logic               u_hit;
    logic               unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign f_idx = fetch_pc[INDEX_W+1:2];
    assign f_tag = fetch_pc[31:INDEX_W+2];
    assign u_idx = update_pc[INDEX_W+1:2];
    assign u_tag = update_pc[31:INDEX_W+2];
    // Instructions are word aligned, so the byte offset never takes part in lookup.
    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    // Lookup sees pre-edge contents; there is deliberately no write bypass.
    always_comb begin
        f_hit             = valid[f_idx] && (tag[f_idx] == f_tag);
        u_hit             = valid[u_idx] && (tag[u_idx] == u_tag);
        btb_found         = f_hit;
        btb_target        = f_hit ? target[f_idx] : 32'h0;
        branch_prediction = f_hit && ctr[f_idx][1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= 32'h0;
                ctr[i]    <= 2'b01;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
        end else if (update_valid) begin
            if (u_hit) begin
                if (update_taken) begin
                    ctr[u_idx]    <= sat_inc(ctr[u_idx]);
                    target[u_idx] <= update_target;
                end else begin
                    ctr[u_idx] <= sat_dec(ctr[u_idx]);
                end
            end else if (update_taken) begin
                // Miss on a taken branch evicts whatever aliases at this index.
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= update_target;
                ctr[u_idx]    <= 2'b10;
            end
        end
    end

endmodule
